// File: rtl/pc_incr.sv
// pc_incr: program-counter offset unit.
// next_pc = curr_pc +/- diff (modulo 2^WIDTH) through one shared
// carry-lookahead adder; wrap flags unsigned overflow on add and borrow on
// subtract. pc_q/wrap_q are one-cycle registered copies of next_pc/wrap.
// The adder is organised as 4-bit lookahead groups whose generate/propagate
// terms feed a second-level lookahead unit, so WIDTH must be a multiple of 4.
// No handshake: inputs are sampled continuously, and registered outputs
// capture on every rising clk edge.
module pc_incr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] curr_pc,
  input  logic             decr,
  input  logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] next_pc,
  output logic             wrap,
  output logic [WIDTH-1:0] pc_q,
  output logic             wrap_q
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] b_op;       // diff, inverted when subtracting
  logic [WIDTH-1:0] g_bit;      // bit generate
  logic [WIDTH-1:0] p_bit;      // bit propagate
  logic [WIDTH-1:0] carry_bit;  // carry into each bit
  logic [NG-1:0]    grp_g;      // group generate
  logic [NG-1:0]    grp_p;      // group propagate
  logic [NG:0]      grp_c;      // carry into each group, grp_c[NG] = carry-out
  logic [WIDTH-1:0] pc_d;
  logic             wrap_d;

  // Operand conditioning: subtraction is curr_pc + ~diff + 1, the +1 being
  // the adder carry-in (decr).
  always_comb begin
    b_op  = diff ^ {WIDTH{decr}};
    g_bit = curr_pc & b_op;
    p_bit = curr_pc ^ b_op;
  end

  // First level: per-group generate/propagate as flat sum-of-products.
  always_comb begin
    logic prod;
    grp_g = '0;
    grp_p = '0;
    prod  = 1'b0;
    for (int g = 0; g < NG; g++) begin
      grp_p[g] = p_bit[4*g] & p_bit[4*g+1] & p_bit[4*g+2] & p_bit[4*g+3];
      for (int j = 0; j < 4; j++) begin
        prod = g_bit[4*g+j];
        for (int k = j + 1; k < 4; k++) begin
          prod = prod & p_bit[4*g+k];
        end
        grp_g[g] = grp_g[g] | prod;
      end
    end
  end

  // Second level: every group carry computed directly from group G/P and
  // the carry-in, so no carry ripples between groups.
  always_comb begin
    logic prod;
    grp_c    = '0;
    grp_c[0] = decr;
    prod     = 1'b0;
    for (int i = 1; i <= NG; i++) begin
      prod = decr;
      for (int k = 0; k < i; k++) begin
        prod = prod & grp_p[k];
      end
      grp_c[i] = prod;
      for (int j = 0; j < i; j++) begin
        prod = grp_g[j];
        for (int k = j + 1; k < i; k++) begin
          prod = prod & grp_p[k];
        end
        grp_c[i] = grp_c[i] | prod;
      end
    end
  end

  // Within each group: bit carries looked ahead from the group carry-in.
  always_comb begin
    logic prod;
    carry_bit = '0;
    prod      = 1'b0;
    for (int g = 0; g < NG; g++) begin
      for (int i = 0; i < 4; i++) begin
        prod = grp_c[g];
        for (int k = 0; k < i; k++) begin
          prod = prod & p_bit[4*g+k];
        end
        carry_bit[4*g+i] = prod;
        for (int j = 0; j < i; j++) begin
          prod = g_bit[4*g+j];
          for (int k = j + 1; k < i; k++) begin
            prod = prod & p_bit[4*g+k];
          end
          carry_bit[4*g+i] = carry_bit[4*g+i] | prod;
        end
      end
    end
  end

  // Sum and wrap: on subtract a missing carry-out means a borrow occurred.
  always_comb begin
    next_pc = p_bit ^ carry_bit;
    wrap    = grp_c[NG] ^ decr;
    pc_d    = next_pc;
    wrap_d  = wrap;
  end

  // Registered copies; synchronous reset overrides the capture of that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_pc_incr.sv
// tb_pc_incr: self-checking bench for pc_incr (WIDTH=16).
module tb_pc_incr;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [15:0] curr_pc;
  logic        decr;
  logic [15:0] diff;
  logic [15:0] next_pc;
  logic        wrap;
  logic [15:0] pc_q;
  logic        wrap_q;

  int checks;
  int errors;

  logic [15:0] exp_q[$];  // expected pc_q after the next edge
  logic        exp_w_q[$];

  pc_incr #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .curr_pc (curr_pc),
    .decr    (decr),
    .diff    (diff),
    .next_pc (next_pc),
    .wrap    (wrap),
    .pc_q    (pc_q),
    .wrap_q  (wrap_q)
  );

  // Clock/reset block: 10 ns period, can be parked low via clk_en.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference model: plain integer arithmetic.
  function automatic void ref_model(input logic [15:0] c, input logic [15:0] d,
                                    input logic dc, output logic [15:0] r,
                                    output logic w);
    int s;
    if (dc) begin
      s = int'(c) - int'(d);
      w = (d > c);
    end else begin
      s = int'(c) + int'(d);
      w = (s > 65535);
    end
    r = s[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (curr_pc=%h diff=%h decr=%b)",
               tag, obs, exp, curr_pc, diff, decr);
    end
  endtask

  task automatic drive(input logic [15:0] c, input logic [15:0] d, input logic dc);
    curr_pc = c;
    diff    = d;
    decr    = dc;
  endtask

  // Drive a vector, wait, check combinational outputs against the model.
  task automatic comb_vec(input string tag, input logic [15:0] c, input logic [15:0] d,
                          input logic dc, input int settle);
    logic [15:0] r;
    logic        w;
    drive(c, d, dc);
    #(settle);
    ref_model(c, d, dc, r, w);
    check({tag, "_pc"}, 32'(next_pc), 32'(r));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  // Directed checks with fixed expected constants.
  task automatic fixed_vec(input string tag, input logic [15:0] c, input logic [15:0] d,
                           input logic dc, input logic [15:0] r, input logic w);
    drive(c, d, dc);
    #10;
    check({tag, "_pc"}, 32'(next_pc), 32'(r));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  initial begin
    logic [15:0] r;
    logic        w;
    logic [15:0] held_pc;
    logic        held_w;
    checks = 0;
    errors = 0;
    clk_en = 1'b1;
    reset  = 1'b1;
    drive(16'h4321, 16'h0101, 1'b0);

    // Reset: registers clear while next_pc keeps tracking inputs.
    @(posedge clk); #1;
    check("rst_pc_q", 32'(pc_q), 32'h0);
    check("rst_wrap_q", 32'(wrap_q), 32'h0);
    check("rst_next_pc", 32'(next_pc), 32'h4422);
    @(negedge clk);
    drive(16'hFFF0, 16'h0020, 1'b0);
    #1;
    check("rst_track_pc", 32'(next_pc), 32'h0010);
    check("rst_track_wrap", 32'(wrap), 32'h1);
    @(posedge clk); #1;
    check("rst2_pc_q", 32'(pc_q), 32'h0);
    check("rst2_wrap_q", 32'(wrap_q), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Randomised registered path: one-cycle latency through a scoreboard.
    for (int i = 0; i < 64; i++) begin
      drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)));
      if (i % 8 == 0) diff = 16'($urandom_range(0, 3));
      ref_model(curr_pc, diff, decr, r, w);
      exp_q.push_back(r);
      exp_w_q.push_back(w);
      #1;
      check("reg_comb_pc", 32'(next_pc), 32'(r));
      @(posedge clk); #1;
      check("reg_pc_q", 32'(pc_q), 32'(exp_q.pop_front()));
      check("reg_wrap_q", 32'(wrap_q), 32'(exp_w_q.pop_front()));
      @(negedge clk);
    end

    // Inputs changing between edges, and a reset pulse between edges,
    // must leave the registers alone.
    held_pc = pc_q;
    held_w  = wrap_q;
    drive(16'h0000, 16'h0001, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("hold_pc_q", 32'(pc_q), 32'(held_pc));
    check("hold_wrap_q", 32'(wrap_q), 32'(held_w));
    check("hold_next_pc", 32'(next_pc), 32'hFFFF);
    @(posedge clk); #1;
    check("after_hold_pc_q", 32'(pc_q), 32'hFFFF);
    check("after_hold_wrap_q", 32'(wrap_q), 32'h1);

    // Reset mid-stream overrides that edge's capture.
    @(negedge clk);
    drive(16'h7000, 16'h1000, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pc_q", 32'(pc_q), 32'h0);
    check("mid_rst_wrap_q", 32'(wrap_q), 32'h0);
    check("mid_rst_next_pc", 32'(next_pc), 32'h8000);
    @(negedge clk);
    reset = 1'b0;
    drive(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    check("release_pc_q", 32'(pc_q), 32'h0100);
    check("release_wrap_q", 32'(wrap_q), 32'h0);

    // Park the clock low; the combinational path must not depend on it.
    @(negedge clk);
    clk_en = 1'b0;
    fixed_vec("add_5_3", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0);
    fixed_vec("sub_3_5", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1);
    fixed_vec("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    fixed_vec("sub_0_1", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1);
    fixed_vec("sub_x_x", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0);
    fixed_vec("add_zero", 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0);
    fixed_vec("sub_zero", 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b0);
    fixed_vec("sub_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    fixed_vec("add_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
    fixed_vec("add_carry_chain", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
    fixed_vec("sub_borrow_chain", 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b0);

    // Low-byte sweep of both operands, both operations.
    for (int c = 0; c < 256; c++) begin
      for (int d = 0; d < 256; d++) begin
        comb_vec("sweep_add", 16'(c), 16'(d), 1'b0, 1);
        comb_vec("sweep_sub", 16'(c), 16'(d), 1'b1, 1);
      end
    end

    // Full-width random vectors.
    for (int i = 0; i < 256; i++) begin
      comb_vec("rand", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), 10);
    end

    // Registers held their last capture while the clock was parked.
    check("idle_pc_q", 32'(pc_q), 32'h0100);
    check("idle_wrap_q", 32'(wrap_q), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
